// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
// Contents:
//   fifo_mode_e - read-side behaviour (STD registered read, FWFT first-word-fall-through)
//   cnt_width   - width of an occupancy counter able to hold 0..depth
//   ptr_width   - width of a pointer able to address depth entries
package fifo_pkg;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultDepth     = 16;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer for a FIFO of arbitrary (non power-of-two) depth.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset, clears the pointer to 0
//   inc - advance the pointer by one entry this cycle
//   ptr - current pointer, always in 0..DEPTH-1
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inc,
  output logic [ptr_width(DEPTH)-1:0] ptr
);

  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d;

  // Explicit compare so non power-of-two depths wrap at DEPTH-1, not at 2**PW-1.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with optional first-word-fall-through read port.
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   wr_en, wr_data            - push request and data
//   rd_en                     - pop request
//   rd_data, rd_valid         - read data and its qualifier (meaning depends on FWFT)
//   full, empty               - occupancy == FIFO_DEPTH / == 0
//   almost_full, almost_empty - occupancy >= AF_THRESH / <= AE_THRESH
//   count                     - current occupancy
//   overflow, underflow       - sticky flags for rejected pushes / pops
//   err_clr                   - clears the sticky flags (a coincident new error still sets)
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DefaultDataWidth,
  parameter int unsigned FIFO_DEPTH = fifo_pkg::DefaultDepth,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_en,
  input  logic [DATA_WIDTH-1:0]                         wr_data,
  input  logic                                          rd_en,
  output logic [DATA_WIDTH-1:0]                         rd_data,
  output logic                                          rd_valid,
  output logic                                          full,
  output logic                                          empty,
  output logic                                          almost_full,
  output logic                                          almost_empty,
  output logic [fifo_pkg::cnt_width(FIFO_DEPTH)-1:0]    count,
  output logic                                          overflow,
  output logic                                          underflow,
  input  logic                                          err_clr
);

  import fifo_pkg::*;

  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam int unsigned PW = ptr_width(FIFO_DEPTH);
  localparam fifo_mode_e Mode = (FWFT != 0) ? fifo_pkg::FWFT : STD;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] head;

  // Status flags depend only on the registered count.
  assign full         = (count_q == CW'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  // No bypass: a pop needs data already stored; a push into a full FIFO
  // only goes ahead when a pop frees the slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  fifo_ptr #(
    .DEPTH(FIFO_DEPTH)
  ) u_wr_ptr (
    .clk(clk),
    .rst(rst),
    .inc(wr_acc),
    .ptr(wr_ptr)
  );

  fifo_ptr #(
    .DEPTH(FIFO_DEPTH)
  ) u_rd_ptr (
    .clk(clk),
    .rst(rst),
    .inc(rd_acc),
    .ptr(rd_ptr)
  );

  assign head = mem_q[rd_ptr];

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    rd_data_d  = rd_acc ? head : rd_data_q;
    rd_valid_d = rd_acc;

    // Set has priority over clear so an error in the clearing cycle is kept.
    overflow_d  = (wr_en && !wr_acc) ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
    underflow_d = (rd_en && !rd_acc) ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a push in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    if (Mode == fifo_pkg::FWFT) begin
      rd_data  = empty ? '0 : head;
      rd_valid = !empty;
    end else begin
      rd_data  = rd_data_q;
      rd_valid = rd_valid_q;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: one standard-read and one FWFT instance driven in lockstep
// (DATA_WIDTH=8, FIFO_DEPTH=5, AF_THRESH=4, AE_THRESH=1).
module tb_param_sync_fifo;

  localparam int unsigned Depth = 5;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       err_clr;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, f_full, s_empty, f_empty;
  logic       s_af, f_af, s_ae, f_ae;
  logic [2:0] s_count, f_count;
  logic       s_ovf, f_ovf, s_unf, f_unf;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  param_sync_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(Depth), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
  );

  param_sync_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(Depth), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the registered-read instance.
  always @(negedge clk) begin
    if (s_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL std_rd_unexpected actual=%0h expected=none", s_rd_data);
      end else begin
        chk("std_rd_data", {24'h0, s_rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    chk({tag, "_count"}, {29'h0, s_count}, n);
    chk({tag, "_full"}, {31'h0, s_full}, {31'h0, n == Depth});
    chk({tag, "_empty"}, {31'h0, s_empty}, {31'h0, n == 0});
    chk({tag, "_af"}, {31'h0, s_af}, {31'h0, n >= 4});
    chk({tag, "_ae"}, {31'h0, s_ae}, {31'h0, n <= 1});
    chk({tag, "_ovf"}, {31'h0, s_ovf}, {31'h0, m_ovf});
    chk({tag, "_unf"}, {31'h0, s_unf}, {31'h0, m_unf});
    chk({tag, "_fwft_count"}, {29'h0, f_count}, n);
    chk({tag, "_fwft_valid"}, {31'h0, f_rd_valid}, {31'h0, n != 0});
    if (n != 0) chk({tag, "_fwft_data"}, {24'h0, f_rd_data}, {24'h0, model_q[0]});
  endtask

  // One clock of stimulus; model and scoreboard are updated from the same inputs.
  task automatic step(input string tag, input logic we, input logic [7:0] wd, input logic re,
                      input logic ec = 1'b0, input logic rs = 1'b0);
    logic rd_ok, wr_ok;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    err_clr = ec;
    rst     = rs;
    if (rs) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = re && (model_q.size() != 0);
      wr_ok = we && ((model_q.size() < Depth) || rd_ok);
      if (rd_ok) exp_q.push_back(model_q.pop_front());
      if (wr_ok) model_q.push_back(wd);
      m_ovf = (we && !wr_ok) ? 1'b1 : (ec ? 1'b0 : m_ovf);
      m_unf = (re && !rd_ok) ? 1'b1 : (ec ? 1'b0 : m_unf);
    end
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    rst     = 1'b0;
    check_state(tag);
  endtask

  initial begin
    wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b1;

    step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("reset_std_rd_data", {24'h0, s_rd_data}, 32'h0);
    chk("reset_std_rd_valid", {31'h0, s_rd_valid}, 32'h0);
    chk("reset_fwft_rd_data", {24'h0, f_rd_data}, 32'h0);
    chk("reset_empty", {31'h0, s_empty}, 32'h1);
    chk("reset_ae", {31'h0, s_ae}, 32'h1);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 5; i++) begin
      step("fill", 1'b1, 8'h11 + 8'(i), 1'b0);
      if (i == 3) chk("af_at_4", {31'h0, s_af}, 32'h1);
      if (i == 3) chk("not_full_at_4", {31'h0, s_full}, 32'h0);
    end
    chk("full_at_5", {31'h0, s_full}, 32'h1);
    step("overflow", 1'b1, 8'h16, 1'b0);
    chk("ovf_set", {31'h0, s_ovf}, 32'h1);
    chk("ovf_count_5", {29'h0, s_count}, 32'd5);

    // Drain, then underflow; clear coinciding with a new error keeps it set.
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 8'h00, 1'b1);
    step("underflow", 1'b0, 8'h00, 1'b1);
    chk("unf_set", {31'h0, s_unf}, 32'h1);
    step("clr_vs_set", 1'b0, 8'h00, 1'b1, 1'b1);
    chk("unf_set_wins", {31'h0, s_unf}, 32'h1);
    chk("ovf_cleared_by_clr", {31'h0, s_ovf}, 32'h0);
    step("err_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_cleared", {31'h0, s_unf}, 32'h0);

    // Simultaneous write and read while full.
    for (int i = 0; i < 5; i++) step("refill", 1'b1, 8'h11 + 8'(i), 1'b0);
    step("full_wr_rd", 1'b1, 8'h66, 1'b1);
    chk("full_wr_rd_count", {29'h0, s_count}, 32'd5);
    chk("full_wr_rd_ovf", {31'h0, s_ovf}, 32'h0);
    for (int i = 0; i < 5; i++) step("drain2", 1'b0, 8'h00, 1'b1);

    // Interleaved traffic at occupancy 0..3 to exercise pointer wrap.
    for (int i = 0; i < 12; i++) step("interleave", 1'b1, 8'h20 + 8'(i), i >= 3);
    for (int i = 0; i < 3; i++) step("interleave_tail", 1'b0, 8'h00, 1'b1);

    // FWFT: a word written into an empty FIFO is visible the next cycle.
    step("fwft_write", 1'b1, 8'hA5, 1'b0);
    chk("fwft_a5_valid", {31'h0, f_rd_valid}, 32'h1);
    chk("fwft_a5_data", {24'h0, f_rd_data}, 32'hA5);
    chk("fwft_a5_not_empty", {31'h0, f_empty}, 32'h0);
    step("fwft_pop", 1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", {31'h0, f_empty}, 32'h1);

    // Reset mid-operation with a write pending and an error flag set.
    step("pre_rst_unf", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'h40 + 8'(i), 1'b0);
    chk("pre_rst_count", {29'h0, s_count}, 32'd3);
    step("mid_rst", 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_count", {29'h0, s_count}, 32'd0);
    chk("mid_rst_empty", {31'h0, s_empty}, 32'h1);
    chk("mid_rst_rd_valid", {31'h0, s_rd_valid}, 32'h0);
    chk("mid_rst_unf", {31'h0, s_unf}, 32'h0);
    step("post_rst_wr", 1'b1, 8'h77, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1);
    step("idle", 1'b0, 8'h00, 1'b0);
    step("idle", 1'b0, 8'h00, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
